// File: rtl/ex_shift_reg_pkg.sv
// Shared constants and sizing helper for the ex_shift_reg LVDS deserializer.
package ex_shift_reg_pkg;

  localparam int unsigned DefWidth    = 8;
  localparam logic [7:0]  DefSyncWord = 8'h55;

  // Bit-counter width: ceil(log2(width)), never below one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned w;
    w = $clog2(width);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/ex_shift_reg_cnt.sv
// Modulo-WIDTH bit counter with synchronous clear and terminal-count flag.
module ex_shift_reg_cnt
  import ex_shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || (cnt_q == CntMax)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CntMax);

endmodule

// File: rtl/ex_shift_reg.sv
// Serial-to-parallel LVDS deserializer with word framing.
// Optional alignment to SYNC_WORD is enabled by defining EX_SHIFT_REG_ALIGN_EN.
module ex_shift_reg
  import ex_shift_reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = DefWidth,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(DefSyncWord)
) (
  input  logic             lvds_clk,
  input  logic             rst,
  input  logic             lvds_in,
  output logic [WIDTH-1:0] lvds_out,
  output logic [WIDTH-1:0] word_out,
  output logic             word_vld,
  output logic             locked
);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             vld_q, vld_d;
  logic             tc;
  logic             cnt_clr;
  logic             take_word;

  always_comb begin
    if (MSB_FIRST) begin
      shift_d = {shift_q[WIDTH-2:0], lvds_in};
    end else begin
      shift_d = {lvds_in, shift_q[WIDTH-1:1]};
    end
  end

  ex_shift_reg_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk_i (lvds_clk),
    .rst_i (rst),
    .clr_i (cnt_clr),
    .tc_o  (tc)
  );

`ifdef EX_SHIFT_REG_ALIGN_EN
  logic locked_q, locked_d;
  logic sync_hit;

  // Compare only until the first match; afterwards framing is counter driven.
  assign sync_hit = !locked_q && (shift_d == SYNC_WORD);

  always_comb begin
    locked_d  = locked_q | sync_hit;
    cnt_clr   = sync_hit;
    take_word = sync_hit | (tc & locked_q);
  end

  always_ff @(posedge lvds_clk or posedge rst) begin
    if (rst) begin
      locked_q <= 1'b0;
    end else begin
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;
`else
  logic unused_sync_word;
  assign unused_sync_word = ^SYNC_WORD;

  always_comb begin
    cnt_clr   = 1'b0;
    take_word = tc;
  end

  assign locked = 1'b1;
`endif

  // On a sync hit shift_d equals SYNC_WORD, so one capture path covers both cases.
  always_comb begin
    word_d = word_q;
    vld_d  = take_word;
    if (take_word) begin
      word_d = shift_d;
    end
  end

  always_ff @(posedge lvds_clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      word_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      word_q  <= word_d;
      vld_q   <= vld_d;
    end
  end

  assign lvds_out = shift_q;
  assign word_out = word_q;
  assign word_vld = vld_q;

endmodule

// File: tb/tb_ex_shift_reg.sv
// Directed self-checking bench for ex_shift_reg (MSB-first and LSB-first instances).
module tb_ex_shift_reg;

  logic       lvds_clk = 1'b0;
  logic       rst      = 1'b1;
  logic       lvds_in  = 1'b0;
  logic [7:0] lvds_out, word_out, lvds_out_l, word_out_l;
  logic       word_vld, locked, word_vld_l, locked_l;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [15:0] Pat = 16'h5511;

  always #5 lvds_clk = ~lvds_clk;

  ex_shift_reg #(
    .WIDTH     (8),
    .MSB_FIRST (1'b1),
    .SYNC_WORD (8'h55)
  ) u_dut (
    .lvds_clk (lvds_clk),
    .rst      (rst),
    .lvds_in  (lvds_in),
    .lvds_out (lvds_out),
    .word_out (word_out),
    .word_vld (word_vld),
    .locked   (locked)
  );

  ex_shift_reg #(
    .WIDTH     (8),
    .MSB_FIRST (1'b0),
    .SYNC_WORD (8'hAA)
  ) u_dut_lsb (
    .lvds_clk (lvds_clk),
    .rst      (rst),
    .lvds_in  (lvds_in),
    .lvds_out (lvds_out_l),
    .word_out (word_out_l),
    .word_vld (word_vld_l),
    .locked   (locked_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, return just after the following rising edge.
  task automatic send_bit(input logic b);
    @(negedge lvds_clk);
    lvds_in = b;
    @(posedge lvds_clk);
    #1;
  endtask

  function automatic logic pat_bit(input int idx);
    logic [15:0] p;
    p = Pat;
    return p[15 - (idx % 16)];
  endfunction

  initial begin
    logic [7:0] exp_word;
    logic [7:0] exp_word_l;
    logic [7:0] pre_words [3];
    int         pulses;
    logic       exp_vld;
    logic       exp_locked;

    // Reset held for 100 ns with a toggling input.
    for (int i = 0; i < 10; i++) begin
      @(negedge lvds_clk);
      lvds_in = i[0];
      @(posedge lvds_clk);
      #1;
      check("rst_lvds_out", 32'(lvds_out), 32'h00);
      check("rst_word_out", 32'(word_out), 32'h00);
      check("rst_word_vld", 32'(word_vld), 32'h0);
    end
`ifdef EX_SHIFT_REG_ALIGN_EN
    check("rst_locked", 32'(locked), 32'h0);
`else
    check("rst_locked", 32'(locked), 32'h1);
`endif
    rst = 1'b0;

    // 256 bits of the repeating 0x5511 pattern.
    exp_word   = 8'h00;
    exp_word_l = 8'h00;
    pulses     = 0;
    for (int i = 0; i < 256; i++) begin
      send_bit(pat_bit(i));
      exp_vld = ((i + 1) % 8 == 0);
      if (exp_vld) begin
        exp_word   = (((i + 1) / 8) % 2 == 1) ? 8'h55 : 8'h11;
        exp_word_l = (((i + 1) / 8) % 2 == 1) ? 8'hAA : 8'h88;
        check("stream_lvds_out", 32'(lvds_out), 32'(exp_word));
        check("stream_lvds_out_lsb", 32'(lvds_out_l), 32'(exp_word_l));
      end
      if (word_vld) pulses++;
      check("stream_word_vld", 32'(word_vld), 32'(exp_vld));
      check("stream_word_out", 32'(word_out), 32'(exp_word));
      check("stream_word_vld_lsb", 32'(word_vld_l), 32'(exp_vld));
      check("stream_word_out_lsb", 32'(word_out_l), 32'(exp_word_l));
    end
    check("stream_pulse_count", 32'(pulses), 32'd32);
    check("stream_locked", 32'(locked), 32'h1);

    // Mid-word reset after 5 bits: outputs clear without waiting for a clock edge.
    for (int i = 0; i < 5; i++) send_bit(pat_bit(i));
    check("mid_pre_lvds_out", 32'(lvds_out), 32'h2A);
    #2;
    rst = 1'b1;
    #1;
    check("mid_async_lvds_out", 32'(lvds_out), 32'h00);
    check("mid_async_word_out", 32'(word_out), 32'h00);
    check("mid_async_word_vld", 32'(word_vld), 32'h0);
    @(posedge lvds_clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_bit(pat_bit(i));
      check("mid_word_vld", 32'(word_vld), (i == 7) ? 32'h1 : 32'h0);
    end
    check("mid_word_out", 32'(word_out), 32'h55);

    // Three-bit 000 prefix ahead of the pattern.
    rst = 1'b1;
    @(posedge lvds_clk);
    #1;
    rst = 1'b0;
`ifdef EX_SHIFT_REG_ALIGN_EN
    pre_words = '{8'h55, 8'h11, 8'h55};
`else
    pre_words = '{8'h0A, 8'hA2, 8'h2A};
`endif
    for (int n = 1; n <= 27; n++) begin
      send_bit((n <= 3) ? 1'b0 : pat_bit(n - 4));
`ifdef EX_SHIFT_REG_ALIGN_EN
      exp_vld    = (n >= 11) && ((n - 11) % 8 == 0);
      exp_locked = (n >= 11);
      if (exp_vld) exp_word = pre_words[(n - 11) / 8];
`else
      exp_vld    = (n % 8 == 0);
      exp_locked = 1'b1;
      if (exp_vld) exp_word = pre_words[n / 8 - 1];
`endif
      if (n == 1) exp_word = 8'h00;
      check("pre_word_vld", 32'(word_vld), 32'(exp_vld));
      check("pre_word_out", 32'(word_out), 32'(exp_word));
      check("pre_locked", 32'(locked), 32'(exp_locked));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_shift_reg.md
Name: ex_shift_reg

Overview:
- Serial-to-parallel deserializer for a single-lane LVDS bit stream.
- Samples `lvds_in` on each rising edge of `lvds_clk` and shifts it into a WIDTH-bit register, exposed continuously on `lvds_out`.
- A bit counter frames the stream into WIDTH-bit words; each completed word is latched with a one-cycle valid strobe.
- Sits directly behind the LVDS input buffer, ahead of byte-level protocol logic.

Parameters:
- WIDTH, 8, deserialized word width in bits (>=2).
- MSB_FIRST, 1: 1 = first received bit ends up in bit WIDTH-1 (shift left, new bit enters bit 0); 0 = first received bit ends up in bit 0 (shift right, new bit enters bit WIDTH-1).
- SYNC_WORD, 8'h55 (WIDTH bits), alignment pattern; used only with ALIGN_EN.

Ports:
- lvds_clk  input  1  sample/shift clock, all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- lvds_in  input  1  serial data; upstream changes it on the falling edge, so it is stable at the rising edge.
- lvds_out  output  WIDTH  live shift-register contents, updated every cycle.
- word_out  output  WIDTH  last completed word, held between strobes.
- word_vld  output  1  one-cycle pulse when word_out is updated.
- locked  output  1  alignment status; tied to 1 when ALIGN_EN is undefined.

Behaviour:
- Reset is asynchronous and active-high on `rst`; single clock domain `lvds_clk`.
- While `rst`=1, all outputs and internal state are held at reset values:
  - lvds_out = 0, word_out = 0, word_vld = 0.
  - bit counter = 0.
  - locked = 0 with ALIGN_EN defined, 1 without.
- Shift, every rising edge with `rst`=0:
  - MSB_FIRST=1: `lvds_out <= {lvds_out[WIDTH-2:0], lvds_in}`.
  - MSB_FIRST=0: `lvds_out <= {lvds_in, lvds_out[WIDTH-1:1]}`.
  - Latency: a bit sampled at edge k is visible on lvds_out after edge k, with no additional pipeline stage.
- Bit counter:
  - Width is ceil(log2(WIDTH)); counts 0..WIDTH-1 and wraps to 0.
  - Counts every cycle out of reset.
- Word completion, on the edge where the counter equals WIDTH-1:
  - word_out <= next shift value, i.e. it includes the bit sampled on that edge.
  - word_vld <= 1 for exactly that following cycle, 0 otherwise.
  - First word_vld occurs after the WIDTH-th sampled bit following reset release.
- Unknown input: X on lvds_in propagates only through the data path; the counter and word_vld never go X.
- Reset asserted mid-word:
  - The partial word is discarded and every register returns to its reset value immediately (asynchronous).
  - Framing restarts at bit 0 on the first edge after release.
- No back-pressure: word_out is overwritten every WIDTH cycles regardless of the consumer.

Optional Feature:
- Macro: EX_SHIFT_REG_ALIGN_EN.
- Defined:
  - While locked=0, word_vld is suppressed.
  - Each cycle the next shift value is compared to SYNC_WORD.
  - On a match: the counter is forced to 0, word_out <= SYNC_WORD, word_vld pulses, and locked is set to 1.
  - Once locked, normal counting applies; the match is no longer checked.
  - locked clears only on reset.
- Undefined: no comparator, locked is tied to 1, and framing is free-running from reset.

Decomposition:
- Shared package `ex_shift_reg_pkg`:
  - default WIDTH constant and default SYNC_WORD constant;
  - function returning the counter width, ceil(log2(WIDTH)).
- One natural sub-module, `ex_shift_reg_cnt`: the modulo-WIDTH bit counter with synchronous load-to-zero, plus its terminal-count output.
- Shift register, word latch and alignment compare stay in the top module.

Test Plan:
- Reset check: hold rst=1 for 100 ns with toggling lvds_in -> lvds_out=0x00, word_out=0x00, word_vld=0 throughout.
- Data pattern, defaults: after reset release, drive 256 bits as the repeating 16-bit pattern 0x5511 MSB-first (0,1,0,1,0,1,0,1,0,0,0,1,0,0,0,1), changing lvds_in on the falling edge:
  - word_vld pulses every 8th cycle;
  - word_out alternates 0x55, 0x11 for 32 words;
  - lvds_out equals 0x55 and 0x11 on the corresponding cycles.
- MSB_FIRST=0 with the same stream -> word_out alternates 0xAA, 0x88.
- Mid-word reset: assert rst after 5 bits of a word -> outputs return to 0 immediately; the next word_vld arrives 8 cycles after release.
- Alignment, EX_SHIFT_REG_ALIGN_EN defined: prefix the stream with 3 random bits ending in 0, then the 0x5511 pattern:
  - locked=0 and no word_vld until 0x55 is first seen;
  - then locked=1, word_out=0x55, then 0x11, 0x55, and so on.
- Alignment, macro undefined, same stream: locked=1 from reset and words are misaligned by 3 bits; with the 3-bit prefix 0b000 the first word_out is 0x0A.
